queue_dispatcher: RTL

- Writer-side counterpart to the round-robin queue reader.
- Accepts one data word per cycle from an upstream source and reads its destination queue index from the word's top bits.
- Issues a one-hot push, with registered data, into one of QUEUE_QUANTITY per-class FIFOs.
- Honours each FIFO's full flag by parking the word in a one-entry hold register and applying backpressure upstream.

---
 rtl/queue_dispatcher_pkg.sv | 22 ++
 rtl/queue_dispatcher_onehot_decoder.sv | 26 ++
 rtl/queue_dispatcher.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/queue_dispatcher_pkg.sv
// -----------------------------------------------------------------------------
// queue_dispatcher_pkg
// Shared definitions for the queue dispatcher and blocks that address the
// same set of per-class FIFOs.
//   sel_bits()     : width of a queue index for a given queue count
//   state_t        : dispatcher state encoding (PASS / HOLD)
//   DROP_CNT_BITS  : width of the discarded-word counter (drop build only)
// -----------------------------------------------------------------------------
package queue_dispatcher_pkg;

    localparam int DROP_CNT_BITS = 8;

    typedef enum logic {
        PASS = 1'b0,   // hold register empty
        HOLD = 1'b1    // a word is parked, waiting for its FIFO to drain
    } state_t;

    function automatic int sel_bits(input int queue_quantity);
        return $clog2(queue_quantity);
    endfunction

endpackage

// File: rtl/queue_dispatcher_onehot_decoder.sv
// -----------------------------------------------------------------------------
// onehot_decoder
// Turns a binary queue index into a one-hot queue select, forced to all zeros
// when i_valid is low.
// Ports:
//   i_sel     [SEL_BITS-1:0]        binary queue index
//   i_valid                         select enable
//   o_onehot  [QUEUE_QUANTITY-1:0]  one-hot select (zero when !i_valid)
// -----------------------------------------------------------------------------
module onehot_decoder #(
    parameter int SEL_BITS       = 2,
    parameter int QUEUE_QUANTITY = 4
) (
    input  logic [SEL_BITS-1:0]       i_sel,
    input  logic                      i_valid,
    output logic [QUEUE_QUANTITY-1:0] o_onehot
);

    genvar gi;
    generate
        for (gi = 0; gi < QUEUE_QUANTITY; gi++) begin : g_bit
            assign o_onehot[gi] = i_valid && (i_sel == SEL_BITS'(gi));
        end
    endgenerate

endmodule

// File: rtl/queue_dispatcher.sv
// -----------------------------------------------------------------------------
// queue_dispatcher
// Routes one upstream word per cycle into one of QUEUE_QUANTITY per-class
// FIFOs, selected by the word's top SEL_BITS bits. The push strobe and data
// are registered (one cycle latency). If the destination FIFO is full, the
// word is parked in a one-entry hold register and upstream is back-pressured
// until that FIFO has room.
//
// Build option: define QUEUE_DISPATCHER_DROP_EN to discard words whose
// destination is full instead of holding them; this adds the drop_count port
// and ties blocked low.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   enb               block enable (low = frozen, no pushes)
//   in_data/in_valid  upstream word and its valid
//   in_ready          combinational accept indication
//   buf_full          per-FIFO full flags (must assert with <=1 slot free)
//   push              registered one-hot write strobe
//   out_data          registered word for the selected FIFO
//   blocked           a word is parked in the hold register
//   drop_count        saturating count of discarded words (drop build only)
// -----------------------------------------------------------------------------
module queue_dispatcher
    import queue_dispatcher_pkg::*;
#(
    parameter int QUEUE_QUANTITY = 4,
    parameter int DATA_BITS      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enb,
    input  logic [DATA_BITS-1:0]      in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [QUEUE_QUANTITY-1:0] buf_full,
    output logic [QUEUE_QUANTITY-1:0] push,
    output logic [DATA_BITS-1:0]      out_data,
    output logic                      blocked
`ifdef QUEUE_DISPATCHER_DROP_EN
    ,
    output logic [DROP_CNT_BITS-1:0]  drop_count
`endif
);

    localparam int SEL_BITS = sel_bits(QUEUE_QUANTITY);

    logic [QUEUE_QUANTITY-1:0] r_push;
    logic [DATA_BITS-1:0]      r_out_data;

    logic [SEL_BITS-1:0]       w_in_dest;
    logic                      w_accept;
    logic                      w_push_valid;
    logic [SEL_BITS-1:0]       w_push_sel;
    logic [DATA_BITS-1:0]      w_out_next;
    logic [QUEUE_QUANTITY-1:0] w_push_onehot;

    assign w_in_dest = in_data[DATA_BITS-1 -: SEL_BITS];
    assign w_accept  = in_valid & in_ready;

`ifdef QUEUE_DISPATCHER_DROP_EN
    logic [DROP_CNT_BITS-1:0] r_drop_count;
    logic                     w_drop;

    assign in_ready = enb & ~rst;
    assign blocked  = 1'b0;

    always_comb begin
        w_push_valid = 1'b0;
        w_push_sel   = w_in_dest;
        w_out_next   = r_out_data;
        w_drop       = 1'b0;
        if (w_accept) begin
            if (!buf_full[w_in_dest]) begin
                w_push_valid = 1'b1;
                w_out_next   = in_data;
            end else begin
                w_drop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_count <= '0;
        end else if (w_drop && (r_drop_count != {DROP_CNT_BITS{1'b1}})) begin
            r_drop_count <= r_drop_count + 1'b1;
        end
    end

    assign drop_count = r_drop_count;
`else
    state_t               r_state;
    state_t               w_state_next;
    logic [DATA_BITS-1:0] r_hold_data;
    logic [SEL_BITS-1:0]  w_hold_dest;
    logic                 w_capture;

    assign w_hold_dest = r_hold_data[DATA_BITS-1 -: SEL_BITS];
    assign in_ready    = enb & ~rst & (r_state == PASS);
    assign blocked     = (r_state == HOLD);

    // All transitions require enb; with enb low the state and hold register
    // stay put and the decoder valid stays low, so push drops to zero.
    always_comb begin
        w_state_next = r_state;
        w_push_valid = 1'b0;
        w_push_sel   = w_in_dest;
        w_out_next   = r_out_data;
        w_capture    = 1'b0;
        if (enb) begin
            case (r_state)
                PASS: begin
                    if (w_accept) begin
                        if (!buf_full[w_in_dest]) begin
                            w_push_valid = 1'b1;
                            w_out_next   = in_data;
                        end else begin
                            w_capture    = 1'b1;
                            w_state_next = HOLD;
                        end
                    end
                end
                HOLD: begin
                    // in_ready is low here, so the release cycle cannot also
                    // accept: this is the single bubble after a stall.
                    if (!buf_full[w_hold_dest]) begin
                        w_push_valid = 1'b1;
                        w_push_sel   = w_hold_dest;
                        w_out_next   = r_hold_data;
                        w_state_next = PASS;
                    end
                end
                default: w_state_next = PASS;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= PASS;
            r_hold_data <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                r_hold_data <= in_data;
            end
        end
    end
`endif

    onehot_decoder #(
        .SEL_BITS       (SEL_BITS),
        .QUEUE_QUANTITY (QUEUE_QUANTITY)
    ) u_push_decoder (
        .i_sel    (w_push_sel),
        .i_valid  (w_push_valid),
        .o_onehot (w_push_onehot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_push     <= '0;
            r_out_data <= '0;
        end else begin
            r_push     <= w_push_onehot;
            r_out_data <= w_out_next;
        end
    end

    assign push     = r_push;
    assign out_data = r_out_data;

endmodule
